// File: rtl/fp_div_pkg.sv
// Constants, state encoding and reciprocal rescale helper for the iterative
// Newton-Raphson single-precision divider.
package fp_div_pkg;

    localparam logic [31:0] SEED_K1     = 32'h3FF0_F0F1;
    localparam logic [31:0] SEED_K0     = 32'h4034_B4B5;
    localparam logic [31:0] FP_TWO      = 32'h4000_0000;
    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_BIAS_M1 = 8'd126;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEED_MUL  = 3'd1,
        S_SEED_ADD  = 3'd2,
        S_IT_MUL1   = 3'd3,
        S_IT_ADD    = 3'd4,
        S_IT_MUL2   = 3'd5,
        S_FINAL_MUL = 3'd6,
        S_DONE      = 3'd7
    } state_e;

    // x approximates 1/D with D in [0.5,1); shift its exponent back so it approximates 1/B.
    function automatic logic [31:0] recip_fix(input logic [31:0] x, input logic b_sign,
                                              input logic [7:0] b_exp);
        logic [7:0] e;
        e = x[30:23] + EXP_BIAS_M1 - b_exp;
        return {b_sign, e, x[22:0]};
    endfunction

endpackage

// File: rtl/fp_div_special_detect.sv
// Flags operand pairs the iterative path cannot handle: zero/denormal or
// inf/NaN divisor, inf/NaN dividend.
module fp_div_special_detect (
    input  logic [7:0] a_exp_i,
    input  logic [7:0] b_exp_i,
    output logic       is_special_o
);
    assign is_special_o = (b_exp_i == 8'h00) || (b_exp_i == 8'hFF) || (a_exp_i == 8'hFF);
endmodule

// File: rtl/fp_div_sequencer.sv
// Sequences seed, Newton-Raphson refinement and the final A*(1/B) product over
// one shared multiplier and one shared adder owned by the parent.
module fp_div_sequencer
    import fp_div_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ITERS   = 3,
    parameter int MUL_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_overflow,
    output logic            out_underflow,
    output logic            out_exception,
    output logic            busy,
    output logic [XLEN-1:0] mul_a,
    output logic [XLEN-1:0] mul_b,
    input  logic [XLEN-1:0] mul_result,
    input  logic            mul_overflow,
    input  logic            mul_underflow,
    input  logic            mul_exception,
    output logic [XLEN-1:0] add_a,
    output logic [XLEN-1:0] add_b,
    input  logic [XLEN-1:0] add_result
);
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(MUL_LAT - 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(ITERS - 1);

    state_e          state_q, state_d;
    logic [31:0]     a_q, a_d;
    logic            b_sign_q, b_sign_d;
    logic [7:0]      b_exp_q, b_exp_d;
    logic [22:0]     d_man_q, d_man_d;
    logic [31:0]     x_q, x_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [31:0]     res_q, res_d;
    logic            ovf_q, ovf_d, unf_q, unf_d, exc_q, exc_d;
    logic            ovld_q, ovld_d;
    logic [31:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0]     add_a_q, add_a_d, add_b_q, add_b_d;
    logic            is_special_s;
    logic [31:0]     d_full_s;

    fp_div_special_detect u_special (
        .a_exp_i      (in_a[30:23]),
        .b_exp_i      (in_b[30:23]),
        .is_special_o (is_special_s)
    );

    assign d_full_s      = {1'b0, EXP_BIAS_M1, d_man_q};
    assign in_ready      = (state_q == S_IDLE) && !rst;
    assign busy          = (state_q != S_IDLE);
    assign out_valid     = ovld_q;
    assign out_result    = res_q;
    assign out_overflow  = ovf_q;
    assign out_underflow = unf_q;
    assign out_exception = exc_q;
    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;
    assign add_a         = add_a_q;
    assign add_b         = add_b_q;

    // Next-state and step operand selection; every shared-unit operand is zero outside its step.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_sign_d = b_sign_q;
        b_exp_d  = b_exp_q;
        d_man_d  = d_man_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        iter_d   = iter_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        exc_d    = exc_q;
        ovld_d   = ovld_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d      = in_a;
                    b_sign_d = in_b[31];
                    b_exp_d  = in_b[30:23];
                    d_man_d  = in_b[22:0];
                    if (is_special_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SEED_MUL;
                        mul_a_d = {1'b0, EXP_BIAS_M1, in_b[22:0]};
                        mul_b_d = SEED_K1;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEED_MUL: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_SEED_ADD;
                    add_a_d = SEED_K0;
                    add_b_d = {1'b1, mul_result[30:0]};
                    mul_a_d = 32'h0;
                    mul_b_d = 32'h0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SEED_ADD: begin
                state_d = S_IT_MUL1;
                x_d     = add_result;
                iter_d  = {IW{1'b0}};
                mul_a_d = d_full_s;
                mul_b_d = add_result;
                cnt_d   = CNT_LOAD;
                add_a_d = 32'h0;
                add_b_d = 32'h0;
            end
            S_IT_MUL1: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_IT_ADD;
                    add_a_d = FP_TWO;
                    add_b_d = {~mul_result[31], mul_result[30:0]};
                    mul_a_d = 32'h0;
                    mul_b_d = 32'h0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IT_ADD: begin
                state_d = S_IT_MUL2;
                mul_a_d = x_q;
                mul_b_d = add_result;
                cnt_d   = CNT_LOAD;
                add_a_d = 32'h0;
                add_b_d = 32'h0;
            end
            S_IT_MUL2: begin
                if (cnt_q == {CW{1'b0}}) begin
                    x_d    = mul_result;
                    iter_d = iter_q + 1'b1;
                    cnt_d  = CNT_LOAD;
                    if (iter_q == ITER_LAST) begin
                        state_d = S_FINAL_MUL;
                        mul_a_d = a_q;
                        mul_b_d = recip_fix(mul_result, b_sign_q, b_exp_q);
                    end else begin
                        state_d = S_IT_MUL1;
                        mul_a_d = d_full_s;
                        mul_b_d = mul_result;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FINAL_MUL: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = S_DONE;
                    res_d   = mul_result;
                    ovf_d   = mul_overflow;
                    unf_d   = mul_underflow;
                    exc_d   = mul_exception;
                    ovld_d  = 1'b1;
                    mul_a_d = 32'h0;
                    mul_b_d = 32'h0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                // Only the special path arrives here with out_valid still low.
                if (!ovld_q) begin
                    res_d  = FP_QNAN;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    exc_d  = 1'b1;
                    ovld_d = 1'b1;
                end else if (out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    ovld_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ovld_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= 32'h0;
            b_sign_q <= 1'b0;
            b_exp_q  <= 8'h0;
            d_man_q  <= 23'h0;
            x_q      <= 32'h0;
            cnt_q    <= {CW{1'b0}};
            iter_q   <= {IW{1'b0}};
            res_q    <= 32'h0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            exc_q    <= 1'b0;
            ovld_q   <= 1'b0;
            mul_a_q  <= 32'h0;
            mul_b_q  <= 32'h0;
            add_a_q  <= 32'h0;
            add_b_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_sign_q <= b_sign_d;
            b_exp_q  <= b_exp_d;
            d_man_q  <= d_man_d;
            x_q      <= x_d;
            cnt_q    <= cnt_d;
            iter_q   <= iter_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            exc_q    <= exc_d;
            ovld_q   <= ovld_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
        end
    end

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Bench for fp_div_sequencer: two instances (MUL_LAT 1 and 3) on real-arithmetic
// multiplier/adder models, quotients compared with the real-valued A/B.
module tb_fp_div_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  in_valid, in_ready, out_valid, out_ready, out_ovf, out_unf, out_exc, busy;
    logic [1:0]  m_ovf, m_unf, m_exc;
    logic [31:0] in_a [2];
    logic [31:0] in_b [2];
    logic [31:0] out_result [2];
    logic [31:0] mul_a [2];
    logic [31:0] mul_b [2];
    logic [31:0] mul_result [2];
    logic [31:0] add_a [2];
    logic [31:0] add_b [2];
    logic [31:0] add_result [2];

    int total = 0;
    int bad   = 0;

    function automatic real f2r(input logic [31:0] f);
        real m;
        if (f[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        m = m * (2.0 ** (real'(f[30:23]) - 127.0));
        return f[31] ? -m : m;
    endfunction

    // Round a real to single precision: {underflow, overflow, bits}.
    function automatic logic [33:0] r2f(input real v);
        real    a;
        int     e;
        int     be;
        longint m;
        if (v == 0.0) return 34'h0;
        a = (v < 0.0) ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        m = longint'(a * 8388608.0);
        if (m >= 64'sd16777216) begin m = 64'sd8388608; e++; end
        be = e + 127;
        if (be >= 255) return {2'b01, v < 0.0, 8'hFF, 23'h0};
        if (be <= 0) return {2'b10, v < 0.0, 31'h0};
        return {2'b00, v < 0.0, be[7:0], m[22:0]};
    endfunction

    function automatic logic [34:0] fmul(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {3'b100, 32'h7FC0_0000};
        return {1'b0, r2f(f2r(a) * f2r(b))};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [33:0] r;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
        r = r2f(f2r(a) + f2r(b));
        return r[31:0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] pa = 32'h0;
        logic [31:0] pb = 32'h0;
        int          age_q = 0;
        int          age_s;
        logic [34:0] prod_s;

        // Multiplier answer is only trustworthy after LAT cycles of stable operands.
        assign age_s          = (mul_a[g] == pa && mul_b[g] == pb) ? age_q + 1 : 0;
        assign prod_s         = fmul(mul_a[g], mul_b[g]);
        assign mul_result[g]  = (age_s >= LAT - 1) ? prod_s[31:0] : 32'hDEAD_BEEF;
        assign m_ovf[g]       = prod_s[32];
        assign m_unf[g]       = prod_s[33];
        assign m_exc[g]       = prod_s[34];
        assign add_result[g]  = fadd(add_a[g], add_b[g]);

        always @(posedge clk) begin
            pa    <= mul_a[g];
            pb    <= mul_b[g];
            age_q <= age_s;
        end

        fp_div_sequencer #(.XLEN(32), .ITERS(3), .MUL_LAT(LAT)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .in_valid      (in_valid[g]),
            .in_ready      (in_ready[g]),
            .in_a          (in_a[g]),
            .in_b          (in_b[g]),
            .out_valid     (out_valid[g]),
            .out_ready     (out_ready[g]),
            .out_result    (out_result[g]),
            .out_overflow  (out_ovf[g]),
            .out_underflow (out_unf[g]),
            .out_exception (out_exc[g]),
            .busy          (busy[g]),
            .mul_a         (mul_a[g]),
            .mul_b         (mul_b[g]),
            .mul_result    (mul_result[g]),
            .mul_overflow  (m_ovf[g]),
            .mul_underflow (m_unf[g]),
            .mul_exception (m_exc[g]),
            .add_a         (add_a[g]),
            .add_b         (add_b[g]),
            .add_result    (add_result[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                              input int tol);
        int   d;
        logic ok;
        d = int'(obs[30:0]) - int'(exp[30:0]);
        if (d < 0) d = -d;
        ok = (obs[31] == exp[31]) && (d <= tol);
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h within %0d ulp", tag, obs, exp, tol);
        end
    endtask

    task automatic start(input int g, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (in_ready[g] !== 1'b1 && n < 50) begin tick(); n++; end
        check("in_ready_before_accept", {31'h0, in_ready[g]}, 32'h1);
        in_a[g]     = a;
        in_b[g]     = b;
        in_valid[g] = 1'b1;
        tick();
        in_valid[g] = 1'b0;
    endtask

    // Counts cycles from the accept edge to out_valid; on the slow instance also
    // checks every multiply step holds its operands for exactly 3 cycles.
    task automatic wait_done(input int g, output int n);
        logic [31:0] pa, pb;
        int          run;
        n   = 0;
        run = 1;
        pa  = mul_a[g];
        pb  = mul_b[g];
        while (out_valid[g] !== 1'b1 && n < 200) begin
            tick();
            n++;
            if (g == 1) begin
                if (mul_a[g] == pa && mul_b[g] == pb) begin
                    run++;
                end else begin
                    if ((pa | pb) != 32'h0) check("mul_step_hold", run, 32'd3);
                    pa  = mul_a[g];
                    pb  = mul_b[g];
                    run = 1;
                end
            end
        end
    endtask

    task automatic finish_out(input int g);
        out_ready[g] = 1'b1;
        tick();
        out_ready[g] = 1'b0;
        check("valid_drops_after_handshake", {31'h0, out_valid[g]}, 32'h0);
        check("ready_after_handshake", {31'h0, in_ready[g]}, 32'h1);
    endtask

    initial begin
        int          n;
        logic [31:0] r0, ra, rb, sa, ma, mb;
        logic [33:0] q;
        logic [31:0] spa [4];
        logic [31:0] spb [4];

        in_valid  = 2'b00;
        out_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin in_a[i] = 32'h0; in_b[i] = 32'h0; end
        spa[0] = 32'h3F80_0000; spb[0] = 32'h0000_0000;
        spa[1] = 32'h3F80_0000; spb[1] = 32'h7F80_0000;
        spa[2] = 32'h7FC0_0001; spb[2] = 32'h4000_0000;
        spa[3] = 32'h4120_0000; spb[3] = 32'h0000_0010;

        // reset state
        tick(); tick();
        check("rst_in_ready", {31'h0, in_ready[0]}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid[0]}, 32'h0);
        check("rst_busy", {31'h0, busy[0]}, 32'h0);
        check("rst_result", out_result[0], 32'h0);
        check("rst_mul_a", mul_a[0], 32'h0);
        check("rst_add_b", add_b[0], 32'h0);
        rst = 1'b0;
        tick();
        check("release_in_ready", {31'h0, in_ready[0]}, 32'h1);

        // 6/2
        start(0, 32'h40C0_0000, 32'h4000_0000);
        check("busy_after_accept", {31'h0, busy[0]}, 32'h1);
        wait_done(0, n);
        check("lat_6div2", n, 32'd12);
        check_near("res_6div2", out_result[0], 32'h4040_0000, 1);
        check("flags_6div2", {29'h0, out_ovf[0], out_unf[0], out_exc[0]}, 32'h0);
        finish_out(0);

        // 1/3 with consumer stalled
        start(0, 32'h3F80_0000, 32'h4040_0000);
        wait_done(0, n);
        check("lat_1div3", n, 32'd12);
        check_near("res_1div3", out_result[0], 32'h3EAA_AAAB, 2);
        r0 = out_result[0];
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", {31'h0, out_valid[0]}, 32'h1);
            check("stall_result", out_result[0], r0);
            check("stall_in_ready", {31'h0, in_ready[0]}, 32'h0);
        end
        finish_out(0);

        // special operands bypass the shared units
        for (int i = 0; i < 4; i++) begin
            start(0, spa[i], spb[i]);
            wait_done(0, n);
            check("lat_special", n, 32'd1);
            check("res_special", out_result[0], 32'h7FC0_0000);
            check("exc_special", {31'h0, out_exc[0]}, 32'h1);
            check("mul_idle_special", mul_a[0] | mul_b[0], 32'h0);
            finish_out(0);
        end

        // reset mid-operation
        start(0, 32'h40C0_0000, 32'h4000_0000);
        for (int i = 0; i < 4; i++) tick();
        check("busy_mid_op", {31'h0, busy[0]}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_valid", {31'h0, out_valid[0]}, 32'h0);
        check("abort_busy", {31'h0, busy[0]}, 32'h0);
        check("abort_mul_a", mul_a[0], 32'h0);
        tick();
        rst = 1'b0;
        start(0, 32'h3F80_0000, 32'h4040_0000);
        wait_done(0, n);
        check("lat_after_abort", n, 32'd12);
        check_near("res_after_abort", out_result[0], 32'h3EAA_AAAB, 2);
        finish_out(0);

        // requests while busy or done are ignored
        start(0, 32'h40C0_0000, 32'h4000_0000);
        tick(); tick(); tick();
        in_a[0] = 32'h4120_0000;
        in_b[0] = 32'h40A0_0000;
        in_valid[0] = 1'b1;
        tick();
        check("ignored_while_busy", {31'h0, in_ready[0]}, 32'h0);
        tick();
        wait_done(0, n);
        check("lat_ignoring", n + 5, 32'd12);
        check_near("res_first_only", out_result[0], 32'h4040_0000, 1);
        tick(); tick();
        check_near("res_held_in_done", out_result[0], 32'h4040_0000, 1);
        finish_out(0);
        tick();
        in_valid[0] = 1'b0;
        check("second_accept_busy", {31'h0, busy[0]}, 32'h1);
        wait_done(0, n);
        check("lat_second", n, 32'd12);
        check_near("res_10div5", out_result[0], 32'h4000_0000, 1);
        finish_out(0);

        // randomized normal operands on the single-cycle multiplier instance
        for (int i = 0; i < 16; i++) begin
            sa = $urandom; ma = $urandom; mb = $urandom;
            ra = $urandom_range(100, 154);
            rb = $urandom_range(100, 154);
            ra = {sa[0], ra[7:0], ma[22:0]};
            rb = {sa[1], rb[7:0], mb[22:0]};
            q  = r2f(f2r(ra) / f2r(rb));
            start(0, ra, rb);
            wait_done(0, n);
            check("lat_rand", n, 32'd12);
            check_near("res_rand", out_result[0], q[31:0], 3);
            check("flags_rand", {29'h0, out_ovf[0], out_unf[0], out_exc[0]},
                  {29'h0, q[32], q[33], 1'b0});
            finish_out(0);
        end

        // three-cycle multiplier instance
        start(1, 32'hC100_0000, 32'h4080_0000);
        wait_done(1, n);
        check("lat_lat3", n, 32'd28);
        check_near("res_lat3", out_result[1], 32'hC000_0000, 1);
        check("flags_lat3", {29'h0, out_ovf[1], out_unf[1], out_exc[1]}, 32'h0);
        finish_out(1);
        for (int i = 0; i < 4; i++) begin
            sa = $urandom; ma = $urandom; mb = $urandom;
            ra = $urandom_range(110, 144);
            rb = $urandom_range(110, 144);
            ra = {sa[0], ra[7:0], ma[22:0]};
            rb = {sa[1], rb[7:0], mb[22:0]};
            q  = r2f(f2r(ra) / f2r(rb));
            start(1, ra, rb);
            wait_done(1, n);
            check("lat_lat3_rand", n, 32'd28);
            check_near("res_lat3_rand", out_result[1], q[31:0], 3);
            finish_out(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_div_sequencer.md
Name: fp_div_sequencer

Overview:
- Iterative controller for Newton-Raphson single-precision division (IEEE-754, XLEN=32).
- Replaces the fully unrolled divider (8 multipliers, 4 adders) with one shared FloatingMultiplication and one FloatingAddition, both instantiated by the parent and driven from this block.
- Sequences seed, ITERS refinement iterations, the reciprocal exponent fix and the final A*(1/B) product.
- Valid/ready in and out; one division in flight.

Parameters:
- XLEN, 32, operand width (only 32 supported).
- ITERS, 3, Newton-Raphson iterations after the seed.
- MUL_LAT, 1, cycles from stable mul operands to valid mul_result (>=1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  high only in IDLE and rst low
- in_a  in  XLEN  dividend A
- in_b  in  XLEN  divisor B
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  consumer accepts
- out_result  out  XLEN  A/B
- out_overflow  out  1  final-multiply overflow
- out_underflow  out  1  final-multiply underflow
- out_exception  out  1  special operand or final-multiply exception
- busy  out  1  state != IDLE
- mul_a, mul_b  out  XLEN  shared multiplier operands
- mul_result  in  XLEN  multiplier result
- mul_overflow, mul_underflow, mul_exception  in  1  multiplier flags
- add_a, add_b  out  XLEN  shared adder operands
- add_result  in  XLEN  adder result, combinational (same cycle)

Behaviour:
- Reset (asynchronous): state IDLE, all output registers 0.
  - out_valid=0, busy=0, out_result/flags=0, mul_*/add_* operands=0.
  - in_ready=0 while rst is high and 1 after release.
- Accept: in_valid&in_ready at an edge latches A and B.
  - Also latches D = {1'b0, 8'd126, B[22:0]} (mantissa of B scaled into [0.5,1)).
- Special path: at accept, if B[30:23] is 0 or 255, or A[30:23] is 255, go directly to DONE.
  - out_result=0x7FC00000, out_exception=1, out_valid one cycle after accept. Shared units are untouched (operands stay 0).
- Normal path states: IDLE -> SEED_MUL -> SEED_ADD -> (IT_MUL1 -> IT_ADD -> IT_MUL2) x ITERS -> FINAL_MUL -> DONE -> IDLE.
- Step operations:
  - SEED_MUL: t = D*0x3FF0F0F1.
  - SEED_ADD: x = 0x4034B4B5 + {1, t[30:0]}.
  - IT_MUL1: t = D*x.
  - IT_ADD: u = 0x40000000 + {~t[31], t[30:0]}.
  - IT_MUL2: x = x*u.
  - Before FINAL_MUL: recip = {B[31], x[30:23]+8'd126-B[30:23] (mod 256), x[22:0]}.
  - FINAL_MUL: A*recip.
- Step timing:
  - Each MUL step holds its operands stable for MUL_LAT cycles, with a down-counter loaded with MUL_LAT-1. mul_result is captured on the last cycle.
  - Each ADD step takes 1 cycle and captures add_result.
- Iteration counter: counts 0..ITERS-1, increments on leaving IT_MUL2, and exits to FINAL_MUL when it equals ITERS-1.
- Latency (normal path): out_valid rises exactly (2*ITERS+2)*MUL_LAT + ITERS + 1 cycles after the accept edge. Defaults give 12.
- DONE:
  - out_result and flags are registered from the FINAL_MUL capture.
  - Outputs stay stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE next cycle; in_ready is 1 the following cycle. There is no same-cycle re-accept.
- in_valid during busy or DONE is ignored; no queuing.
- Reset mid-operation aborts immediately: outputs clear, and no partial result is ever presented.

Decomposition:
- Package fp_div_pkg holds:
  - constants SEED_K1=0x3FF0F0F1, SEED_K0=0x4034B4B5, FP_TWO=0x40000000, FP_QNAN=0x7FC00000, EXP_BIAS_M1=8'd126;
  - the state enum typedef.
- One combinational sub-module, fp_div_special_detect: takes A and B, outputs is_special.
- FSM, counters and operand muxes stay in fp_div_sequencer.

Test Plan:
- A=0x40C00000, B=0x40000000 (6/2) -> out_result 0x40400000 ±1 ulp; out_valid exactly 12 cycles after accept; flags 0.
- A=0x3F800000, B=0x40400000 (1/3) -> 0x3EAAAAAB ±2 ulp; hold out_ready=0 for 10 cycles -> result and out_valid stable; in_ready=0 throughout.
- B=0x00000000 -> out_result 0x7FC00000, out_exception=1, out_valid 1 cycle after accept, mul_a/mul_b remain 0.
- Assert rst at cycle 5 of the 6/2 division -> out_valid=0 and busy=0 immediately; after release, a 1/3 division completes correctly in 12 cycles.
- Pulse in_valid with A=0x41200000, B=0x40A00000 while busy -> not accepted; only the first result appears; a second accept occurs only after the out handshake.
- MUL_LAT=3, ITERS=3, A=0xC1000000, B=0x40800000 -> 0xC0000000 ±1 ulp, latency 28 cycles, mul operands constant across each 3-cycle step.
